mdu_req_arbiter: RTL and testbench

- Shares the single multiply/divide unit (mdu_top) between two requesters, r0 and r1.
- Typical requesters are the integer pipe and a second issue port or helper unit.
- Grants requesters round-robin, issues one operation at a time, captures the result into a local buffer and returns it over a valid/ready response channel.
- Guards against illegal (divide) opcodes and against a hung MDU with a watchdog timeout.

---
 rtl/mdu_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mdu_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_req_arbiter.sv
// mdu_req_arbiter
//   Shares one multiply/divide unit between two requesters (r0, r1).
//   Requests are granted round-robin, one operation is in flight at a time,
//   and the result is held in a local buffer until the owner consumes it.
//   Divide opcodes (funct3[2]=1) never reach the MDU; they get an immediate
//   error response. A watchdog returns an error if the MDU stops responding.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   rN_req_valid/ready/funct3/in_*  request channel per requester
//   rN_rsp_valid/ready/data/err     response channel per requester
//   mdu_in_valid/funct3/in_1/in_2   issue interface to the MDU
//   mdu_out/out_valid/busy          MDU result and backpressure
//   mdu_cpu_busy                    asserted while a result waits for pickup
//   timeout_flag                    sticky watchdog-fired indicator
module mdu_req_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_req_valid,
    output logic            r0_req_ready,
    input  logic [2:0]      r0_funct3,
    input  logic [XLEN-1:0] r0_in_1,
    input  logic [XLEN-1:0] r0_in_2,
    output logic            r0_rsp_valid,
    input  logic            r0_rsp_ready,
    output logic [XLEN-1:0] r0_rsp_data,
    output logic            r0_rsp_err,
    input  logic            r1_req_valid,
    output logic            r1_req_ready,
    input  logic [2:0]      r1_funct3,
    input  logic [XLEN-1:0] r1_in_1,
    input  logic [XLEN-1:0] r1_in_2,
    output logic            r1_rsp_valid,
    input  logic            r1_rsp_ready,
    output logic [XLEN-1:0] r1_rsp_data,
    output logic            r1_rsp_err,
    output logic            mdu_in_valid,
    output logic [2:0]      mdu_funct3,
    output logic [XLEN-1:0] mdu_in_1,
    output logic [XLEN-1:0] mdu_in_2,
    output logic            mdu_cpu_busy,
    input  logic [XLEN-1:0] mdu_out,
    input  logic            mdu_out_valid,
    input  logic            mdu_busy,
    output logic            timeout_flag
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic            owner, last_grant;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] in1_q, in2_q, data_q;
    logic            err_q;
    logic [CW-1:0]   cnt;

    // Round-robin pick: on contention the requester not served last wins;
    // otherwise whichever one is valid (don't-care when neither is).
    logic            any_req, gnt_sel;
    logic [2:0]      sel_f3;
    logic [XLEN-1:0] sel_in1, sel_in2;
    logic            cnt_hit, own_rsp_ready;

    assign any_req       = r0_req_valid | r1_req_valid;
    assign gnt_sel       = (r0_req_valid & r1_req_valid) ? ~last_grant : r1_req_valid;
    assign sel_f3        = gnt_sel ? r1_funct3 : r0_funct3;
    assign sel_in1       = gnt_sel ? r1_in_1 : r0_in_1;
    assign sel_in2       = gnt_sel ? r1_in_2 : r0_in_2;
    assign cnt_hit       = (cnt == CW'(TIMEOUT - 1));
    assign own_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;

    assign mdu_funct3 = funct3_q;
    assign mdu_in_1   = in1_q;
    assign mdu_in_2   = in2_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        r0_rsp_data  = '0;
        r1_rsp_data  = '0;
        r0_rsp_err   = 1'b0;
        r1_rsp_err   = 1'b0;
        mdu_in_valid = 1'b0;
        mdu_cpu_busy = 1'b0;
        case (state)
            IDLE: if (any_req) begin
                r0_req_ready = ~gnt_sel;
                r1_req_ready = gnt_sel;
                state_nxt    = sel_f3[2] ? RESP : ISSUE;
            end
            ISSUE: begin
                mdu_in_valid = 1'b1;
                if (!mdu_busy) state_nxt = WAIT;
            end
            // A result on the limit cycle still counts as a good result.
            WAIT: if (mdu_out_valid || cnt_hit) state_nxt = RESP;
            RESP: begin
                mdu_cpu_busy = 1'b1;
                if (owner) begin
                    r1_rsp_valid = 1'b1;
                    r1_rsp_data  = data_q;
                    r1_rsp_err   = err_q;
                end else begin
                    r0_rsp_valid = 1'b1;
                    r0_rsp_data  = data_q;
                    r0_rsp_err   = err_q;
                end
                if (own_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            funct3_q     <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner    <= gnt_sel;
                    funct3_q <= sel_f3;
                    in1_q    <= sel_in1;
                    in2_q    <= sel_in2;
                    if (sel_f3[2]) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                ISSUE: if (!mdu_busy) cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (mdu_out_valid) begin
                        data_q <= mdu_out;
                        err_q  <= 1'b0;
                    end else if (cnt_hit) begin
                        data_q       <= '0;
                        err_q        <= 1'b1;
                        timeout_flag <= 1'b1;
                    end
                end
                RESP: if (own_rsp_ready) last_grant <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_req_arbiter.sv
module tb_mdu_req_arbiter;

    localparam int TO = 8;

    logic        clk = 0, rst = 0;
    logic        r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
    logic        r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
    logic [2:0]  r0_funct3, r1_funct3, mdu_funct3;
    logic [31:0] r0_in_1, r0_in_2, r0_rsp_data, r1_in_1, r1_in_2, r1_rsp_data;
    logic        mdu_in_valid, mdu_cpu_busy, mdu_out_valid, mdu_busy, timeout_flag;
    logic [31:0] mdu_in_1, mdu_in_2, mdu_out;

    mdu_req_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_funct3(r0_funct3),
        .r0_in_1(r0_in_1), .r0_in_2(r0_in_2), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_funct3(r1_funct3),
        .r1_in_1(r1_in_1), .r1_in_2(r1_in_2), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
        .mdu_in_valid(mdu_in_valid), .mdu_funct3(mdu_funct3), .mdu_in_1(mdu_in_1),
        .mdu_in_2(mdu_in_2), .mdu_cpu_busy(mdu_cpu_busy), .mdu_out(mdu_out),
        .mdu_out_valid(mdu_out_valid), .mdu_busy(mdu_busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {logic owner; logic [31:0] data; logic err;} exp_t;
    exp_t q[$];

    int total = 0, bad = 0;
    int cyc = 0, lat_last = 0, issue_cnt = 0, inval_cycles = 0, acc_total = 0, r1_act = 0;
    int acc_cyc[2];
    bit hang = 0, late_req = 0;
    int mdu_lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic o, input logic [31:0] d, input logic e);
        exp_t x;
        x.owner = o; x.data = d; x.err = e;
        q.push_back(x);
    endtask

    // Monitor / scoreboard: pops an expectation on every response handshake.
    initial begin
        logic p0, p1;
        exp_t e;
        p0 = 0; p1 = 0;
        forever begin
            @(negedge clk);
            if (r0_req_valid && r0_req_ready) begin acc_cyc[0] = cyc; acc_total++; end
            if (r1_req_valid && r1_req_ready) begin acc_cyc[1] = cyc; acc_total++; end
            if (r0_rsp_valid && !p0) lat_last = cyc - acc_cyc[0];
            if (r1_rsp_valid && !p1) lat_last = cyc - acc_cyc[1];
            p0 = r0_rsp_valid; p1 = r1_rsp_valid;
            if (mdu_in_valid) inval_cycles++;
            if (mdu_in_valid && !mdu_busy) issue_cnt++;
            if (r1_rsp_valid || r1_req_ready || r1_rsp_err || r1_rsp_data != 0) r1_act++;
            if (r0_rsp_valid && r1_rsp_valid) begin
                bad++;
                $display("FAIL both_rsp_valid: got 1 expected 0");
            end
            for (int n = 0; n < 2; n++) begin
                if (n == 0 ? (r0_rsp_valid && r0_rsp_ready) : (r1_rsp_valid && r1_rsp_ready)) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rsp: got response on r%0d expected none", n);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_owner", 64'(n), 64'(e.owner));
                        chk("rsp_data", n == 0 ? r0_rsp_data : r1_rsp_data, e.data);
                        chk("rsp_err", n == 0 ? r0_rsp_err : r1_rsp_err, e.err);
                    end
                end
            end
        end
    end

    // MDU model: returns in_1*in_2 mdu_lat cycles after an accepted issue.
    initial begin
        logic [31:0] a, b;
        bit late_seen;
        late_seen = 0; mdu_out_valid = 0; mdu_out = 0;
        forever begin
            @(negedge clk);
            if (late_req != late_seen) begin
                late_seen = late_req;
                @(posedge clk); #1 mdu_out_valid = 1; mdu_out = 32'hDEAD;
                @(posedge clk); #1 mdu_out_valid = 0;
            end else if (mdu_in_valid && !mdu_busy && !hang) begin
                a = mdu_in_1; b = mdu_in_2;
                @(posedge clk);
                repeat (mdu_lat - 1) @(posedge clk);
                #1 mdu_out_valid = 1; mdu_out = a * b;
                @(posedge clk); #1 mdu_out_valid = 0;
            end
        end
    end

    task automatic send(input int n, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        if (n == 0) begin r0_funct3 = f; r0_in_1 = a; r0_in_2 = b; r0_req_valid = 1; end
        else        begin r1_funct3 = f; r1_in_1 = a; r1_in_2 = b; r1_req_valid = 1; end
        forever begin
            @(negedge clk);
            if (n == 0 ? r0_req_ready : r1_req_ready) break;
            if (++k > 300) begin
                total++; bad++;
                $display("FAIL accept_timeout: r%0d not accepted after %0d cycles", n, k);
                break;
            end
        end
        @(posedge clk); #1;
        if (n == 0) r0_req_valid = 0; else r1_req_valid = 0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 400) begin @(negedge clk); k++; end
        chk("drain_pending", 64'(q.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); @(negedge clk);
        chk("reset_outs", 64'(|{r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
            r0_rsp_data, r1_rsp_data, r0_rsp_err, r1_rsp_err, mdu_in_valid, mdu_funct3,
            mdu_in_1, mdu_in_2, mdu_cpu_busy, timeout_flag}), 0);
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        int i0, v0, a0, k;
        bit ok;
        r0_req_valid = 0; r1_req_valid = 0; r0_rsp_ready = 1; r1_rsp_ready = 1;
        r0_funct3 = 0; r1_funct3 = 0; r0_in_1 = 0; r0_in_2 = 0; r1_in_1 = 0; r1_in_2 = 0;
        mdu_busy = 0;
        do_reset();

        // single r0 multiply, 7*6
        push(0, 42, 0);
        i0 = issue_cnt; v0 = inval_cycles; a0 = r1_act;
        send(0, 3'b000, 7, 6);
        drain();
        chk("lat_legal", 64'(lat_last), 3);
        chk("issue_once", 64'(issue_cnt - i0), 1);
        chk("in_valid_cycles", 64'(inval_cycles - v0), 1);
        chk("r1_quiet", 64'(r1_act - a0), 0);

        // simultaneous requests after reset: r0 first
        do_reset();
        push(0, 15, 0); push(1, 32'hFFFFFFFE, 0);
        fork
            send(0, 3'b000, 3, 5);
            send(1, 3'b000, 32'hFFFFFFFF, 2);
        join
        drain();

        // six back-to-back with both held valid: r0,r1,r0,r1,r0,r1
        for (int i = 0; i < 3; i++) begin push(0, 15, 0); push(1, 8, 0); end
        r0_funct3 = 0; r0_in_1 = 3; r0_in_2 = 5;
        r1_funct3 = 0; r1_in_1 = 2; r1_in_2 = 4;
        a0 = acc_total; r0_req_valid = 1; r1_req_valid = 1;
        k = 0;
        while (acc_total - a0 < 6 && k < 300) begin @(posedge clk); #1; k++; end
        r0_req_valid = 0; r1_req_valid = 0;
        chk("b2b_accepts", 64'(acc_total - a0), 6);
        drain();

        // illegal divide from r1
        push(1, 0, 1);
        i0 = issue_cnt; v0 = inval_cycles;
        send(1, 3'b100, 5, 5);
        drain();
        chk("lat_illegal", 64'(lat_last), 1);
        chk("illegal_no_issue", 64'(issue_cnt - i0), 0);
        chk("illegal_no_in_valid", 64'(inval_cycles - v0), 0);

        // MDU busy for 5 cycles in ISSUE
        push(0, 32'h200, 0);
        mdu_busy = 1; i0 = issue_cnt; v0 = inval_cycles;
        send(0, 3'b000, 16, 32);
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!(mdu_in_valid && mdu_in_1 == 16 && mdu_in_2 == 32 && mdu_funct3 == 0)) ok = 0;
        end
        chk("busy_operands_stable", 64'(ok), 1);
        chk("busy_no_issue", 64'(issue_cnt - i0), 0);
        @(posedge clk); #1 mdu_busy = 0;
        drain();
        chk("busy_issue_once", 64'(issue_cnt - i0), 1);
        chk("busy_in_valid_cycles", 64'(inval_cycles - v0), 6);

        // response stalled 4 cycles while r1 waits
        push(0, 32'h9C, 0); push(1, 6, 0);
        r0_rsp_ready = 0;
        send(0, 3'b000, 12, 13);
        k = 0;
        while (!r0_rsp_valid && k < 50) begin @(negedge clk); k++; end
        chk("stall_rsp_seen", 64'(r0_rsp_valid), 1);
        @(posedge clk); #1;
        r1_funct3 = 0; r1_in_1 = 2; r1_in_2 = 3; r1_req_valid = 1;
        ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (!(r0_rsp_valid && r0_rsp_data == 32'h9C && !r0_rsp_err && mdu_cpu_busy &&
                  !r1_req_ready && !r1_rsp_valid)) ok = 0;
        end
        chk("stall_hold", 64'(ok), 1);
        @(posedge clk); #1 r0_rsp_ready = 1;
        send(1, 3'b000, 2, 3);
        drain();

        // MDU hang -> watchdog error, sticky flag
        push(0, 0, 1);
        hang = 1;
        send(0, 3'b000, 1, 1);
        drain();
        chk("lat_timeout", 64'(lat_last), TO + 2);
        chk("timeout_flag_set", 64'(timeout_flag), 1);
        hang = 0;
        push(1, 9, 0);
        send(1, 3'b000, 3, 3);
        drain();
        chk("timeout_flag_sticky", 64'(timeout_flag), 1);

        // reset mid-WAIT, late result ignored, next op normal
        hang = 1;
        send(0, 3'b000, 4, 4);
        repeat (3) @(posedge clk);
        do_reset();
        hang = 0;
        late_req = ~late_req;
        ok = 0;
        repeat (5) begin
            @(negedge clk);
            if (r0_rsp_valid || r1_rsp_valid || mdu_cpu_busy) ok = 1;
        end
        chk("late_result_ignored", 64'(ok), 0);
        @(posedge clk); #1;
        push(0, 25, 0);
        send(0, 3'b000, 5, 5);
        drain();
        chk("post_reset_lat", 64'(lat_last), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
